// File: rtl/qeciphy_rx_link_ctrl.sv
// RX link sequencing controller for qeciphy_rx_channeldecoder: owns the decoder
// enable, enforces the enable-low interval, stages bring-up and bounds retries.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// IDLE        | link down, waiting for start_i
// HOLDOFF     | enable low until low_cnt reaches MIN_LOW_CYCLES
// WAIT_RDY    | enable high, waiting for local rx_rdy_i
// WAIT_REMOTE | enable high, waiting for remote_rx_rdy_i
// LINK_UP     | link established
// FAILED      | retries exhausted, enable low until clear_i
module qeciphy_rx_link_ctrl #(
  parameter int MIN_LOW_CYCLES = 16,
  parameter int RDY_TIMEOUT    = 4096,
  parameter int MAX_RETRIES    = 3,
  localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               clear_i,
  input  logic               rx_rdy_i,
  input  logic               remote_rx_rdy_i,
  input  logic               rx_fault_fatal_i,
  input  logic [3:0]         rx_error_code_i,
  output logic               dec_enable_o,
  output logic               link_up_o,
  output logic               fault_o,
  output logic [3:0]         error_code_o,
  output logic [RETRY_W-1:0] retry_cnt_o,
  output logic [2:0]         state_o
);

  localparam int LOW_W = (MIN_LOW_CYCLES < 1) ? 1 : $clog2(MIN_LOW_CYCLES + 1);
  localparam int TMR_W = (RDY_TIMEOUT < 2) ? 1 : $clog2(RDY_TIMEOUT);

  localparam logic [LOW_W-1:0]   LOW_MIN  = LOW_W'(MIN_LOW_CYCLES);
  localparam logic [TMR_W-1:0]   TMO_LAST = TMR_W'(RDY_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RTY_MAX  = RETRY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    HOLDOFF     = 3'd1,
    WAIT_RDY    = 3'd2,
    WAIT_REMOTE = 3'd3,
    LINK_UP     = 3'd4,
    FAILED      = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic               dec_enable_q, dec_enable_d;
  logic               link_up_q, link_up_d;
  logic               fault_q, fault_d;
  logic [3:0]         error_code_q, error_code_d;
  logic [RETRY_W-1:0] retry_cnt_q, retry_cnt_d;
  logic [LOW_W-1:0]   low_cnt_q, low_cnt_d;
  logic [TMR_W-1:0]   timer_q, timer_d;

  logic               evt;
  logic [3:0]         evt_code;
  logic               clr_err;
  logic               clr_retry;
  logic               timeout;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      dec_enable_q <= 1'b0;
      link_up_q    <= 1'b0;
      fault_q      <= 1'b0;
      error_code_q <= '0;
      retry_cnt_q  <= '0;
      low_cnt_q    <= '0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      dec_enable_q <= dec_enable_d;
      link_up_q    <= link_up_d;
      fault_q      <= fault_d;
      error_code_q <= error_code_d;
      retry_cnt_q  <= retry_cnt_d;
      low_cnt_q    <= low_cnt_d;
      timer_q      <= timer_d;
    end
  end

  assign timeout = ((state_q == WAIT_RDY) || (state_q == WAIT_REMOTE)) && (timer_q == TMO_LAST);

  always_comb begin
    state_d   = state_q;
    evt       = 1'b0;
    evt_code  = 4'h0;
    clr_err   = 1'b0;
    clr_retry = 1'b0;
    if (stop_i && (state_q != FAILED)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d   = HOLDOFF;
            clr_err   = 1'b1;
            clr_retry = 1'b1;
          end
        end
        HOLDOFF: begin
          if (low_cnt_q >= LOW_MIN) state_d = WAIT_RDY;
        end
        WAIT_RDY: begin
          if (rx_fault_fatal_i) begin
            evt      = 1'b1;
            evt_code = rx_error_code_i;
          end else if (timeout) begin
            evt      = 1'b1;
            evt_code = 4'hF;
          end else if (rx_rdy_i) begin
            state_d = WAIT_REMOTE;
          end
        end
        WAIT_REMOTE: begin
          if (rx_fault_fatal_i) begin
            evt      = 1'b1;
            evt_code = rx_error_code_i;
          end else if (!rx_rdy_i) begin
            evt      = 1'b1;
            evt_code = 4'hE;
          end else if (timeout) begin
            evt      = 1'b1;
            evt_code = 4'hF;
          end else if (remote_rx_rdy_i) begin
            state_d   = LINK_UP;
            clr_retry = 1'b1;
          end
        end
        LINK_UP: begin
          // remote readiness only gates entry; its loss here is ignored
          if (rx_fault_fatal_i) begin
            evt      = 1'b1;
            evt_code = rx_error_code_i;
          end else if (!rx_rdy_i) begin
            evt      = 1'b1;
            evt_code = 4'hE;
          end
        end
        FAILED: begin
          if (clear_i) begin
            state_d   = IDLE;
            clr_err   = 1'b1;
            clr_retry = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
      if (evt) state_d = (retry_cnt_q < RTY_MAX) ? HOLDOFF : FAILED;
    end
  end

  // Outputs are computed from state_d so each registered output flips with the state.
  always_comb begin
    dec_enable_d = (state_d == WAIT_RDY) || (state_d == WAIT_REMOTE) || (state_d == LINK_UP);
    link_up_d    = (state_d == LINK_UP);
    fault_d      = (state_d == FAILED);

    error_code_d = error_code_q;
    if (evt)          error_code_d = evt_code;
    else if (clr_err) error_code_d = 4'h0;

    retry_cnt_d = retry_cnt_q;
    if (clr_retry)                          retry_cnt_d = '0;
    else if (evt && (retry_cnt_q < RTY_MAX)) retry_cnt_d = retry_cnt_q + 1'b1;

    low_cnt_d = low_cnt_q;
    if (dec_enable_q)              low_cnt_d = '0;
    else if (low_cnt_q < LOW_MIN)  low_cnt_d = low_cnt_q + 1'b1;

    timer_d = (state_d != state_q) ? '0 : timer_q + 1'b1;
  end

  assign dec_enable_o = dec_enable_q;
  assign link_up_o    = link_up_q;
  assign fault_o      = fault_q;
  assign error_code_o = error_code_q;
  assign retry_cnt_o  = retry_cnt_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_qeciphy_rx_link_ctrl.sv
// Directed bench for qeciphy_rx_link_ctrl with an enable-low-interval monitor.
module tb_qeciphy_rx_link_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, stop = 1'b0, clear = 1'b0;
  logic       rx_rdy = 1'b0, remote_rdy = 1'b0, fatal = 1'b0;
  logic [3:0] err_in = 4'h0;
  logic       dec_enable_o, link_up_o, fault_o;
  logic [3:0] error_code_o;
  logic [1:0] retry_cnt_o;
  logic [2:0] state_o;

  int n_tests = 0;
  int n_fail  = 0;

  qeciphy_rx_link_ctrl dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .start_i          (start),
    .stop_i           (stop),
    .clear_i          (clear),
    .rx_rdy_i         (rx_rdy),
    .remote_rx_rdy_i  (remote_rdy),
    .rx_fault_fatal_i (fatal),
    .rx_error_code_i  (err_in),
    .dec_enable_o     (dec_enable_o),
    .link_up_o        (link_up_o),
    .fault_o          (fault_o),
    .error_code_o     (error_code_o),
    .retry_cnt_o      (retry_cnt_o),
    .state_o          (state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts post-edge samples with enable low, stopping at the first high sample.
  task automatic wait_enable(output int n);
    n = 0;
    while (!dec_enable_o && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic count_high(output int n);
    n = 0;
    while (dec_enable_o && n < 5000) begin
      n++;
      tick();
    end
  endtask

  // Every rising edge of the enable must follow at least 16 low samples.
  int   low_run = 0;
  logic en_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      low_run = 0;
      en_prev = 1'b0;
    end else begin
      if (dec_enable_o && !en_prev) check("en_low_run_ge16", 32'(low_run >= 16), 1);
      if (!dec_enable_o) begin
        if (low_run < 1000) low_run++;
      end else begin
        low_run = 0;
      end
      en_prev = dec_enable_o;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int first_rise;

    // reset state
    repeat (3) tick();
    check("rst_state", state_o, 0);
    check("rst_enable", dec_enable_o, 0);
    check("rst_outputs", {link_up_o, fault_o, error_code_o, retry_cnt_o}, 0);
    rst = 1'b0;

    // bring-up: start at cycle 0, rx_rdy after edge 25, remote after edge 30
    start = 1'b1;
    tick();
    start = 1'b0;
    check("holdoff_entry", state_o, 1);
    first_rise = 0;
    for (int k = 2; k <= 31; k++) begin
      tick();
      if (dec_enable_o && first_rise == 0) first_rise = k;
      if (k == 25) rx_rdy = 1'b1;
      if (k == 26) check("wait_remote", state_o, 3);
      if (k == 30) begin
        check("linkup_pre", link_up_o, 0);
        remote_rdy = 1'b1;
      end
    end
    check("first_rise_edge", first_rise, 17);
    check("linkup", link_up_o, 1);
    check("linkup_state", state_o, 4);

    // fatal fault in LINK_UP
    err_in = 4'h3;
    fatal  = 1'b1;
    tick();
    fatal = 1'b0;
    check("fatal_code", error_code_o, 4'h3);
    check("fatal_retry", retry_cnt_o, 1);
    check("fatal_state", state_o, 1);
    check("fatal_en_low", dec_enable_o, 0);
    wait_enable(n);
    check("fatal_low_len", n, 17);
    tick();
    tick();
    check("relink_state", state_o, 4);
    check("relink_retry", retry_cnt_o, 0);

    // loss of rx_rdy in LINK_UP
    rx_rdy = 1'b0;
    tick();
    check("rdyloss_code", error_code_o, 4'hE);
    check("rdyloss_state", state_o, 1);
    check("rdyloss_linkup", link_up_o, 0);
    rx_rdy = 1'b1;
    wait_enable(n);
    check("rdyloss_low_len", n, 17);
    tick();
    tick();
    check("restore_linkup", link_up_o, 1);
    check("restore_retry", retry_cnt_o, 0);

    // stop and fatal together in WAIT_REMOTE: stop wins
    rx_rdy     = 1'b0;
    remote_rdy = 1'b0;
    tick();
    rx_rdy = 1'b1;
    wait_enable(n);
    tick();
    check("pre_stop_state", state_o, 3);
    stop   = 1'b1;
    fatal  = 1'b1;
    err_in = 4'h5;
    tick();
    stop  = 1'b0;
    fatal = 1'b0;
    check("stop_state", state_o, 0);
    check("stop_retry", retry_cnt_o, 1);
    check("stop_code", error_code_o, 4'hE);
    check("stop_en", dec_enable_o, 0);

    // timeouts with rx_rdy held low
    rx_rdy = 1'b0;
    start  = 1'b1;
    tick();
    start = 1'b0;
    check("tmo_start_clr", {error_code_o, retry_cnt_o}, 0);
    for (int a = 1; a <= 4; a++) begin
      wait_enable(n);
      if (a > 1) check("tmo_low_len", n, 17);
      count_high(n);
      check("tmo_high_len", n, 4096);
      check("tmo_code", error_code_o, 4'hF);
      check("tmo_retry", retry_cnt_o, (a < 4) ? a : 3);
      check("tmo_state", state_o, (a < 4) ? 1 : 5);
    end
    check("failed_fault", fault_o, 1);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("failed_sticky", state_o, 5);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_state", state_o, 0);
    check("clear_code", error_code_o, 0);
    check("clear_fault", {fault_o, retry_cnt_o}, 0);

    // async reset during WAIT_RDY
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_enable(n);
    check("pre_rst_state", state_o, 2);
    rst = 1'b1;
    #1;
    check("async_rst_en", dec_enable_o, 0);
    check("async_rst_state", state_o, 0);
    tick();
    rst = 1'b0;

    // random stimulus; the negedge monitor checks every enable rise
    for (int c = 0; c < 3000; c++) begin
      start      = ($urandom_range(3) == 0);
      stop       = ($urandom_range(40) == 0);
      clear      = ($urandom_range(15) == 0);
      rx_rdy     = ($urandom_range(9) != 0);
      remote_rdy = ($urandom_range(3) != 0);
      fatal      = ($urandom_range(60) == 0);
      err_in     = 4'($urandom_range(15));
      if (c == 1500) rst = 1'b1;
      if (c == 1503) rst = 1'b0;
      tick();
    end
    {start, stop, clear, rx_rdy, remote_rdy, fatal} = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
